symbol_code_extractor: RTL and testbench

- Upstream feeder of the LiDAR entropy decoder's symbol decode lookup stage.
- Unpacks the packed entropy bitstream (WORD_W-bit words from the input FIFO, MSB-first) into fixed-width CODE_W-bit symbol codes.
- Drives the downstream lookup's decode_en/symbol_code pair.
- Tracks frame boundaries, discards residual tail bits and reports frame completion.

---
 rtl/entropy_dec_pkg.sv | 18 +
 rtl/bit_buffer_shifter.sv | 57 +++++
 rtl/symbol_code_extractor.sv | 111 +++++++++++
 tb/tb_symbol_code_extractor.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/entropy_dec_pkg.sv
// Constants, state type and width helpers shared by the entropy decoder front end
// (symbol code extractor and symbol lookup stage).
package entropy_dec_pkg;

  localparam int WORD_W_DEF = 32;
  localparam int CODE_W_DEF = 8;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    DONE
  } ext_state_e;

  function automatic int resid_w(input int code_w);
    return $clog2(code_w) + 1;
  endfunction

endpackage

// File: rtl/bit_buffer_shifter.sv
// Left-aligned bit buffer with a valid-bit count; consumes CODE_W bits from the top
// and appends a WORD_W word below the surviving bits, both possibly in the same cycle.
module bit_buffer_shifter #(
  parameter int WORD_W = 32,
  parameter int CODE_W = 8,
  parameter int BUF_W  = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WORD_W-1:0]          push_data,
  output logic [CODE_W-1:0]          top_code,
  output logic [$clog2(BUF_W+1)-1:0] count
);

  localparam int CNT_W = $clog2(BUF_W + 1);

  logic [BUF_W-1:0] buf_q, buf_d, kept, word_top;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_kept;

  // Bits below the valid count are kept at zero, so appending is a plain OR.
  always_comb begin
    kept     = buf_q;
    cnt_kept = cnt_q;
    if (pop) begin
      kept     = buf_q << CODE_W;
      cnt_kept = cnt_q - CNT_W'(CODE_W);
    end
    word_top = BUF_W'(push_data) << (BUF_W - WORD_W);
    buf_d    = kept;
    cnt_d    = cnt_kept;
    if (push) begin
      buf_d = kept | (word_top >> cnt_kept);
      cnt_d = cnt_kept + CNT_W'(WORD_W);
    end
    if (clear) begin
      buf_d = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_q <= '0;
      cnt_q <= '0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
    end
  end

  assign top_code = buf_q[BUF_W-1 -: CODE_W];
  assign count    = cnt_q;

endmodule

// File: rtl/symbol_code_extractor.sv
// Unpacks MSB-first bitstream words into CODE_W symbol codes with frame tracking.
// Optional SYMEXT_SYMCOUNT_EN adds a saturating per-frame code counter (sym_count).
//   state | meaning
//   RUN   | accepting words of the current frame, emitting codes
//   DRAIN | last word taken; emitting remaining whole codes
//   DONE  | frame_done pulse; residual tail bits reported
module symbol_code_extractor
  import entropy_dec_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int CODE_W = CODE_W_DEF,
  parameter int BUF_W  = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [WORD_W-1:0]           in_data,
  input  logic                        in_valid,
  input  logic                        in_last,
  output logic                        in_ready,
  input  logic                        out_ready,
  output logic                        decode_en,
  output logic [CODE_W-1:0]           symbol_code,
  output logic                        frame_done,
  output logic [resid_w(CODE_W)-1:0]  residual_bits
`ifdef SYMEXT_SYMCOUNT_EN
  ,
  output logic [15:0]                 sym_count
`endif
);

  localparam int CNT_W = $clog2(BUF_W + 1);
  localparam int RES_W = resid_w(CODE_W);
  localparam logic [CNT_W-1:0] CODE_CNT = CNT_W'(CODE_W);
  localparam logic [CNT_W-1:0] FILL_MAX = CNT_W'(BUF_W - WORD_W);

  ext_state_e       state_q, state_d;
  logic [CNT_W-1:0] count;
  logic [CODE_W-1:0] top_code;
  logic             accept, emit, flush;
  logic             decode_en_q;
  logic [CODE_W-1:0] code_q;
  logic [RES_W-1:0] resid_q;

  // Reset gating keeps in_ready low while reset is held even though RUN is the reset state.
  assign in_ready = !reset && (state_q == RUN) && (count <= FILL_MAX);
  assign accept   = in_valid && in_ready;
  assign emit     = out_ready && (count >= CODE_CNT);
  assign flush    = (state_q == DRAIN) && (count < CODE_CNT);

  bit_buffer_shifter #(
    .WORD_W(WORD_W),
    .CODE_W(CODE_W),
    .BUF_W (BUF_W)
  ) u_buf (
    .clk      (clk),
    .reset    (reset),
    .clear    (flush),
    .push     (accept),
    .pop      (emit),
    .push_data(in_data),
    .top_code (top_code),
    .count    (count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      decode_en_q <= 1'b0;
      code_q      <= '0;
      resid_q     <= '0;
    end else begin
      state_q     <= state_d;
      decode_en_q <= emit;
      if (emit) code_q <= top_code;
      if (flush) resid_q <= RES_W'(count);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (accept && in_last) state_d = DRAIN;
      DRAIN:   if (flush) state_d = DONE;
      DONE:    state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  assign decode_en     = decode_en_q;
  assign symbol_code   = code_q;
  assign frame_done    = (state_q == DONE);
  assign residual_bits = resid_q;

`ifdef SYMEXT_SYMCOUNT_EN
  logic [15:0] sym_q;

  // Holds through the DONE cycle, clears as the FSM returns to RUN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sym_q <= '0;
    end else if (state_q == DONE) begin
      sym_q <= '0;
    end else if (emit && (sym_q != 16'hFFFF)) begin
      sym_q <= sym_q + 16'd1;
    end
  end

  assign sym_count = sym_q;
`endif

endmodule

// File: tb/tb_symbol_code_extractor.sv
// Bench for symbol_code_extractor: bit-queue reference model checked every cycle,
// plus directed frames with literal code/residual expectations.
module tb_symbol_code_extractor;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic        in_ready, decode_en, frame_done;
  logic [7:0]  symbol_code;
  logic [3:0]  residual_bits;

  logic [31:0] b_data = '0;
  logic        b_valid = 1'b0, b_last = 1'b0, b_oready = 1'b1;
  logic        b_ready, b_dec, b_fd;
  logic [4:0]  b_code;
  logic [3:0]  b_res;
`ifdef SYMEXT_SYMCOUNT_EN
  logic [15:0] sym_count, b_sym;
`endif

  symbol_code_extractor dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_ready(out_ready), .decode_en(decode_en),
    .symbol_code(symbol_code), .frame_done(frame_done), .residual_bits(residual_bits)
`ifdef SYMEXT_SYMCOUNT_EN
    , .sym_count(sym_count)
`endif
  );

  symbol_code_extractor #(.CODE_W(5)) dut5 (
    .clk(clk), .reset(reset), .in_data(b_data), .in_valid(b_valid), .in_last(b_last),
    .in_ready(b_ready), .out_ready(b_oready), .decode_en(b_dec),
    .symbol_code(b_code), .frame_done(b_fd), .residual_bits(b_res)
`ifdef SYMEXT_SYMCOUNT_EN
    , .sym_count(b_sym)
`endif
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the frame's unconsumed bits as a plain queue, earliest bit first.
  bit          mq[$];
  logic        m_closed = 1'b0;
  logic        e_dec = 1'b0, e_fd = 1'b0;
  logic [7:0]  e_code = '0;
  logic [3:0]  e_res = '0;
  logic [15:0] m_syms = '0;

  task automatic model_step();
    int sz;
    logic take, pop, finish;
    logic [7:0] c;
    sz     = mq.size();
    take   = in_valid && !m_closed && !e_fd && (sz <= 32);
    pop    = out_ready && (sz >= 8);
    finish = m_closed && (sz < 8);
    if (e_fd) begin
      e_fd   = 1'b0;
      e_dec  = 1'b0;
      m_syms = '0;
    end else if (finish) begin
      e_res    = 4'(sz);
      mq.delete();
      m_closed = 1'b0;
      e_fd     = 1'b1;
      e_dec    = 1'b0;
    end else begin
      e_dec = pop;
      if (pop) begin
        c = '0;
        for (int i = 0; i < 8; i++) c = {c[6:0], mq.pop_front()};
        e_code = c;
        if (m_syms != 16'hFFFF) m_syms = m_syms + 16'd1;
      end
      if (take) begin
        for (int i = 31; i >= 0; i--) mq.push_back(in_data[i]);
        if (in_last) m_closed = 1'b1;
      end
    end
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      mq.delete();
      m_closed = 1'b0;
      e_dec = 1'b0;
      e_fd = 1'b0;
      e_code = '0;
      e_res = '0;
      m_syms = '0;
    end else begin
      model_step();
    end
  end

  logic [7:0]  seen[$];
  int          fd_count = 0;
  logic [3:0]  res_at_fd = '0;
  logic [15:0] sym_at_fd = '0;

  initial forever begin
    @(negedge clk);
    chk("cyc_in_ready", {63'd0, in_ready}, {63'd0, (!reset && !m_closed && !e_fd && (mq.size() <= 32))});
    chk("cyc_decode_en", {63'd0, decode_en}, {63'd0, e_dec});
    chk("cyc_symbol_code", {56'd0, symbol_code}, {56'd0, e_code});
    chk("cyc_frame_done", {63'd0, frame_done}, {63'd0, e_fd});
    chk("cyc_residual", {60'd0, residual_bits}, {60'd0, e_res});
`ifdef SYMEXT_SYMCOUNT_EN
    chk("cyc_sym_count", {48'd0, sym_count}, {48'd0, m_syms});
    if (frame_done) sym_at_fd = sym_count;
`endif
    if (decode_en) seen.push_back(symbol_code);
    if (frame_done) begin
      fd_count++;
      res_at_fd = residual_bits;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    chk("send_ready_wait", {63'd0, n < 200}, 64'd1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_fd(input int target);
    int n;
    n = 0;
    while (fd_count < target && n < 500) begin
      tick();
      n++;
    end
    chk("wait_frame_done", {63'd0, n < 500}, 64'd1);
  endtask

  task automatic cmp_seen(input string nm, input logic [7:0] expq[$]);
    chk({nm, "_ncodes"}, 64'(seen.size()), 64'(expq.size()));
    for (int i = 0; i < expq.size(); i++)
      if (i < seen.size()) chk({nm, "_code"}, {56'd0, seen[i]}, {56'd0, expq[i]});
  endtask

  initial begin
    logic [7:0] expq[$];
    int fd0, n5, nfd5;
    logic [3:0] r5;

    #1 reset = 1'b1;
    #2;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_decode_en", {63'd0, decode_en}, 64'd0);
    chk("rst_symbol_code", {56'd0, symbol_code}, 64'd0);
    chk("rst_frame_done", {63'd0, frame_done}, 64'd0);
    chk("rst_residual", {60'd0, residual_bits}, 64'd0);
    tick();
    tick();
    #1 reset = 1'b0;
    tick();

    // Single word, four codes.
    seen.delete();
    fd0 = fd_count;
    send(32'h12345678, 1'b1);
    wait_fd(fd0 + 1);
    expq = '{8'h12, 8'h34, 8'h56, 8'h78};
    cmp_seen("t1", expq);
    chk("t1_residual", {60'd0, res_at_fd}, 64'd0);
`ifdef SYMEXT_SYMCOUNT_EN
    chk("t1_sym_at_done", {48'd0, sym_at_fd}, 64'd4);
    tick();
    chk("t1_sym_cleared", {48'd0, sym_count}, 64'd0);
`else
    tick();
`endif

    // Two-word frame, eight codes.
    seen.delete();
    fd0 = fd_count;
    send(32'hC0C1C2C3, 1'b0);
    send(32'hC4C5C6C7, 1'b1);
    wait_fd(fd0 + 1);
    expq = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6, 8'hC7};
    cmp_seen("t8", expq);
`ifdef SYMEXT_SYMCOUNT_EN
    chk("t8_sym_at_done", {48'd0, sym_at_fd}, 64'd8);
`endif
    tick();

    // Streaming four back-to-back words.
    seen.delete();
    fd0 = fd_count;
    for (int i = 0; i < 4; i++) send(32'hA5A5A5A5, 1'(i == 3));
    wait_fd(fd0 + 1);
    expq.delete();
    for (int i = 0; i < 16; i++) expq.push_back(8'hA5);
    cmp_seen("stream", expq);
    repeat (5) tick();
    chk("stream_one_frame_done", 64'(fd_count), 64'(fd0 + 1));

    // Backpressure: buffer fills to 64 bits and stalls.
    seen.delete();
    fd0 = fd_count;
    out_ready = 1'b0;
    send(32'h01020304, 1'b0);
    send(32'h05060708, 1'b0);
    repeat (10) begin
      chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
      chk("bp_no_decode", {63'd0, decode_en}, 64'd0);
      tick();
    end
    out_ready = 1'b1;
    send(32'h090A0B0C, 1'b1);
    wait_fd(fd0 + 1);
    expq.delete();
    for (int i = 1; i <= 12; i++) expq.push_back(8'(i));
    cmp_seen("bp", expq);
    tick();

    // Reset in DRAIN after two of four codes.
    seen.delete();
    send(32'h11223344, 1'b1);
    begin
      int n;
      n = 0;
      while (seen.size() < 2 && n < 100) begin
        tick();
        n++;
      end
      chk("rst_mid_wait", {63'd0, n < 100}, 64'd1);
    end
    fd0 = fd_count;
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_decode_en", {63'd0, decode_en}, 64'd0);
    chk("mid_rst_symbol_code", {56'd0, symbol_code}, 64'd0);
    chk("mid_rst_frame_done", {63'd0, frame_done}, 64'd0);
    chk("mid_rst_residual", {60'd0, residual_bits}, 64'd0);
    chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd0);
    tick();
    tick();
    #1 reset = 1'b0;
    repeat (8) tick();
    chk("mid_rst_no_frame_done", 64'(fd_count), 64'(fd0));
    seen.delete();
    send(32'hDEADBEEF, 1'b1);
    wait_fd(fd0 + 1);
    expq = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    cmp_seen("post_rst", expq);
    tick();

    // CODE_W=5 instance: six 0x1F codes, two tail bits dropped.
    n5 = 0;
    nfd5 = 0;
    r5 = '0;
    chk("c5_in_ready", {63'd0, b_ready}, 64'd1);
    b_valid = 1'b1;
    b_data  = 32'hFFFFFFFF;
    b_last  = 1'b1;
    tick();
    b_valid = 1'b0;
    b_last  = 1'b0;
    repeat (20) begin
      tick();
      if (b_dec) begin
        n5++;
        chk("c5_code", {59'd0, b_code}, 64'h1F);
      end
      if (b_fd) begin
        nfd5++;
        r5 = b_res;
`ifdef SYMEXT_SYMCOUNT_EN
        chk("c5_sym_at_done", {48'd0, b_sym}, 64'd6);
`endif
      end
    end
    chk("c5_ncodes", 64'(n5), 64'd6);
    chk("c5_nframe_done", 64'(nfd5), 64'd1);
    chk("c5_residual", {60'd0, r5}, 64'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
